// File: rtl/pl_reg_fd_q.sv
// Fetch/decode pipeline queue: DEPTH-entry in-order buffer between the fetch
// and decode stages with valid/ready on both sides, a synchronous flush-all
// and a per-thread kill that squashes only the matching thread's entries.
// Killed entries keep their slot and are dropped silently when they reach the head.
module pl_reg_fd_q #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BITS_THREADS  = 3,
  parameter int DEPTH         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      kill_en_i,
  input  logic [BITS_THREADS-1:0]   kill_tid_i,
  input  logic                      valid_f_i,
  output logic                      ready_f_o,
  input  logic [ADDRESS_WIDTH-1:0]  pc_f_i,
  input  logic [ADDRESS_WIDTH-1:0]  pc_plus4_f_i,
  input  logic [DATA_WIDTH-1:0]     instr_f_i,
  input  logic [BITS_THREADS-1:0]   tid_f_i,
  output logic                      valid_d_o,
  input  logic                      ready_d_i,
  output logic [ADDRESS_WIDTH-1:0]  pc_d_o,
  output logic [ADDRESS_WIDTH-1:0]  pc_plus4_d_o,
  output logic [DATA_WIDTH-1:0]     instr_d_o,
  output logic [BITS_THREADS-1:0]   tid_d_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);

  // Entry storage; payload fields carry no reset-relevant meaning once the live bit is clear.
  logic [ADDRESS_WIDTH-1:0] pc_q       [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q [DEPTH];
  logic [DATA_WIDTH-1:0]    instr_q    [DEPTH];
  logic [BITS_THREADS-1:0]  tid_q      [DEPTH];
  logic [DEPTH-1:0]         live_q, live_d;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic nonempty_s;
  logic head_live_s;
  logic ready_s;
  logic valid_s;
  logic push_s;
  logic pop_s;
  logic push_live_s;

  // Handshake qualifiers, all derived from stored state (ready never looks at ready_d_i).
  always_comb begin
    nonempty_s  = (count_q != {CW{1'b0}});
    head_live_s = live_q[rd_ptr_q];
    ready_s     = (count_q < DEPTH_C);
    valid_s     = nonempty_s & head_live_s;
    push_s      = valid_f_i & ready_s;
    // A dead head is retired every cycle without waiting for decode.
    pop_s       = (valid_s & ready_d_i) | (nonempty_s & ~head_live_s);
    // A beat from the thread being killed this cycle is accepted but born dead.
    push_live_s = ~(kill_en_i & (kill_tid_i == tid_f_i));
  end

  // Next-state for pointers, occupancy and live bits; clr overrides everything else.
  always_comb begin
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      live_d   = {DEPTH{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        live_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        live_d[i] = live_d[i] & ~(kill_en_i & (tid_q[i] == kill_tid_i));
      end
      // The write slot is always empty when pushing, so this cannot collide with a pop.
      if (push_s) begin
        live_d[wr_ptr_q] = push_live_s;
        wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q   <= {DEPTH{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Capture the fetch payload into the slot at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]       <= {ADDRESS_WIDTH{1'b0}};
        pc_plus4_q[i] <= {ADDRESS_WIDTH{1'b0}};
        instr_q[i]    <= {DATA_WIDTH{1'b0}};
        tid_q[i]      <= {BITS_THREADS{1'b0}};
      end
    end else if (push_s & ~clr) begin
      pc_q[wr_ptr_q]       <= pc_f_i;
      pc_plus4_q[wr_ptr_q] <= pc_plus4_f_i;
      instr_q[wr_ptr_q]    <= instr_f_i;
      tid_q[wr_ptr_q]      <= tid_f_i;
    end else begin
      pc_q[wr_ptr_q]       <= pc_q[wr_ptr_q];
      pc_plus4_q[wr_ptr_q] <= pc_plus4_q[wr_ptr_q];
      instr_q[wr_ptr_q]    <= instr_q[wr_ptr_q];
      tid_q[wr_ptr_q]      <= tid_q[wr_ptr_q];
    end
  end

  // Decode-side view: head entry when valid, all-zero otherwise.
  always_comb begin
    if (valid_s) begin
      pc_d_o       = pc_q[rd_ptr_q];
      pc_plus4_d_o = pc_plus4_q[rd_ptr_q];
      instr_d_o    = instr_q[rd_ptr_q];
      tid_d_o      = tid_q[rd_ptr_q];
    end else begin
      pc_d_o       = {ADDRESS_WIDTH{1'b0}};
      pc_plus4_d_o = {ADDRESS_WIDTH{1'b0}};
      instr_d_o    = {DATA_WIDTH{1'b0}};
      tid_d_o      = {BITS_THREADS{1'b0}};
    end
  end

  assign ready_f_o = ready_s;
  assign valid_d_o = valid_s;
  assign count_o   = count_q;

endmodule

// File: tb/tb_pl_reg_fd_q.sv
// Bench for pl_reg_fd_q: a queue-of-entries reference model plus a scoreboard
// of expected decode beats, checked by an independent negedge monitor.
module tb_pl_reg_fd_q;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TB    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          kill_en_i;
  logic [TB-1:0] kill_tid_i;
  logic          valid_f_i;
  logic          ready_f_o;
  logic [AW-1:0] pc_f_i;
  logic [AW-1:0] pc_plus4_f_i;
  logic [DW-1:0] instr_f_i;
  logic [TB-1:0] tid_f_i;
  logic          valid_d_o;
  logic          ready_d_i;
  logic [AW-1:0] pc_d_o;
  logic [AW-1:0] pc_plus4_d_o;
  logic [DW-1:0] instr_d_o;
  logic [TB-1:0] tid_d_o;
  logic [CW-1:0] count_o;

  pl_reg_fd_q #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BITS_THREADS(TB), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .kill_en_i(kill_en_i), .kill_tid_i(kill_tid_i),
    .valid_f_i(valid_f_i), .ready_f_o(ready_f_o),
    .pc_f_i(pc_f_i), .pc_plus4_f_i(pc_plus4_f_i),
    .instr_f_i(instr_f_i), .tid_f_i(tid_f_i),
    .valid_d_o(valid_d_o), .ready_d_i(ready_d_i),
    .pc_d_o(pc_d_o), .pc_plus4_d_o(pc_plus4_d_o),
    .instr_d_o(instr_d_o), .tid_d_o(tid_d_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
    logic [DW-1:0] instr;
    logic [TB-1:0] tid;
    bit            live;
  } ent_t;

  ent_t mq[$];     // every occupied slot, live or dead, in FIFO order
  ent_t exp_q[$];  // beats decode is still owed
  ent_t mon_e;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance the reference model by one clock edge using the inputs currently applied.
  task automatic model_step();
    ent_t e;
    ent_t tmp[$];
    bit   pop;
    bit   push;
    if (clr) begin
      mq.delete();
      exp_q.delete();
      return;
    end
    pop  = (mq.size() > 0) && (!mq[0].live || ready_d_i);
    push = valid_f_i && (mq.size() < DEPTH);
    if (pop) void'(mq.pop_front());
    if (kill_en_i) begin
      foreach (mq[i]) if (mq[i].tid == kill_tid_i) mq[i].live = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].tid != kill_tid_i) tmp.push_back(exp_q[i]);
      exp_q = tmp;
    end
    if (push) begin
      e.pc    = pc_f_i;
      e.pc4   = pc_plus4_f_i;
      e.instr = instr_f_i;
      e.tid   = tid_f_i;
      e.live  = !(kill_en_i && (kill_tid_i == tid_f_i));
      mq.push_back(e);
      if (e.live) exp_q.push_back(e);
    end
  endtask

  task automatic drive(input bit vf, input logic [AW-1:0] pc, input logic [TB-1:0] tid,
                       input bit rdy, input bit ke = 1'b0, input logic [TB-1:0] kt = 3'd0,
                       input bit c = 1'b0);
    valid_f_i    = vf;
    pc_f_i       = pc;
    pc_plus4_f_i = pc + 32'd4;
    instr_f_i    = $urandom;
    tid_f_i      = tid;
    ready_d_i    = rdy;
    kill_en_i    = ke;
    kill_tid_i   = kt;
    clr          = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: compare status every cycle and pop the scoreboard on each decode handshake.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("count_o", count_o, mq.size());
      check("ready_f_o", ready_f_o, mq.size() < DEPTH);
      check("valid_d_o", valid_d_o, (mq.size() > 0) && mq[0].live);
      if (valid_d_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: decode shows pc=0x%0h with no beat expected", pc_d_o);
        end else begin
          mon_e = exp_q[0];
          if (ready_d_i) void'(exp_q.pop_front());
          check("pc_d_o", pc_d_o, mon_e.pc);
          check("pc_plus4_d_o", pc_plus4_d_o, mon_e.pc4);
          check("instr_d_o", instr_d_o, mon_e.instr);
          check("tid_d_o", tid_d_o, mon_e.tid);
        end
      end else begin
        check("idle_zero", |{pc_d_o, pc_plus4_d_o, instr_d_o, tid_d_o}, 1'b0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_f", ready_f_o, 1'b1);
    check("rst_valid_d", valid_d_o, 1'b0);
    check("rst_count", count_o, 0);
    check("rst_zero", |{pc_d_o, pc_plus4_d_o, instr_d_o, tid_d_o}, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Back-to-back pushes with decode always ready.
    drive(1'b1, 32'h100, 3'd1, 1'b1); tick();
    drive(1'b1, 32'h104, 3'd2, 1'b1); tick();
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (3) tick();

    // Stall decode, overfill by one, then release.
    for (int k = 0; k <= DEPTH; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 3'd7, 1'b0); tick();
    end
    drive(1'b1, 32'h100 + 32'(4 * DEPTH), 3'd7, 1'b1); repeat (2) tick();
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (DEPTH + 2) tick();

    // Kill thread 3 while stalled; decode must see only tids 5 and 6.
    drive(1'b1, 32'h200, 3'd3, 1'b0); tick();
    drive(1'b1, 32'h204, 3'd5, 1'b0); tick();
    drive(1'b1, 32'h208, 3'd3, 1'b0); tick();
    drive(1'b1, 32'h20c, 3'd6, 1'b0); tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 3'd3); tick();
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (DEPTH + 3) tick();

    // Push from the thread being killed in the same cycle, then a clean push.
    drive(1'b1, 32'h300, 3'd4, 1'b1, 1'b1, 3'd4); tick();
    drive(1'b1, 32'h304, 3'd4, 1'b1); tick();
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (3) tick();

    // clr with a simultaneous push on a two-entry queue.
    drive(1'b1, 32'h400, 3'd1, 1'b0); tick();
    drive(1'b1, 32'h404, 3'd2, 1'b0); tick();
    drive(1'b1, 32'h408, 3'd3, 1'b0, 1'b0, 3'd0, 1'b1); tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0); tick();
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (2) tick();

    // Asynchronous reset mid-cycle with two entries held.
    drive(1'b1, 32'h500, 3'd1, 1'b0); tick();
    drive(1'b1, 32'h504, 3'd2, 1'b0); tick();
    drive(1'b0, 32'h0, 3'd0, 1'b0); tick();
    #1 rst = 1'b1;
    #1;
    check("arst_valid_d", valid_d_o, 1'b0);
    check("arst_count", count_o, 0);
    check("arst_ready_f", ready_f_o, 1'b1);
    mq.delete();
    exp_q.delete();
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (3) tick();

    // Continuous streaming across several pointer wraps.
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(1'b1, 32'h600 + 32'(4 * k), 3'(k), 1'b1); tick();
    end
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (DEPTH + 2) tick();

    // Randomized traffic with kills and occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(99) < 70, $urandom, 3'($urandom_range(7)),
            $urandom_range(99) < 60, $urandom_range(99) < 10,
            3'($urandom_range(7)), $urandom_range(99) < 2);
      tick();
    end
    drive(1'b0, 32'h0, 3'd0, 1'b1); repeat (2 * DEPTH + 2) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
